move_scheduler: RTL
===================

Name: move_scheduler

Overview:
- Buffers coordinated-move commands decoded by the SPI message handler in a small FIFO.
- Sequences them one at a time into the stepper timing datapath (the DDA step generator), holding its move parameters stable for the whole move.
- Issues a start pulse per move, waits for the executor's done pulse, then launches the next move with a fixed gap.
- Supports abort and reports queue depth, completed-move count, busy and underrun status for SPI readback.

Parameters:
- DEPTH, 4, number of queued moves (power of two, at least 2).
- MOVE_WIDTH, 64, width of duration, increment and incrementincrement.
- COUNT_WIDTH, 32, width of the completed-move counter.

Ports:
- CLK  in  1  system clock (16 MHz).
- reset  in  1  synchronous reset, active high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO accepts the command this cycle.
- cmd_dir  in  1  direction bit.
- cmd_last  in  1  marks the final move of a sequence.
- cmd_duration  in  MOVE_WIDTH  move length in ticks.
- cmd_increment  in  MOVE_WIDTH  signed initial increment.
- cmd_incrementincrement  in  MOVE_WIDTH  signed increment delta.
- abort  in  1  flush the queue and stop the executor.
- move_start  out  1  one-cycle launch pulse to the executor.
- move_dir  out  1  current move direction.
- move_duration  out  MOVE_WIDTH  current move duration.
- move_increment  out  MOVE_WIDTH  current move increment.
- move_incrementincrement  out  MOVE_WIDTH  current move increment delta.
- move_done  in  1  one-cycle pulse from the executor when its tick count reaches 0.
- move_abort  out  1  one-cycle stop pulse to the executor.
- busy  out  1  high when state is not IDLE.
- queue_count  out  $clog2(DEPTH+1)  FIFO occupancy.
- moves_completed  out  COUNT_WIDTH  completed-move counter; wraps modulo 2^COUNT_WIDTH.
- underrun  out  1  sticky starvation flag.
- underrun_clear  in  1  clears underrun.

Behaviour:
- Reset (synchronous, active high):
  - State IDLE, FIFO empty, all move_* registers 0.
  - move_start, move_abort, underrun and moves_completed are 0.
  - cmd_ready is 0 while reset is high.
- cmd_ready = !reset && (queue_count < DEPTH) && state != ABORT.
  - Combinational; it does not look ahead to a pop in the same cycle, so a full FIFO refuses a push even while popping.
- Push: cmd_valid && cmd_ready writes {dir, last, duration, increment, incrementincrement} at the tail. queue_count updates on the next edge.
- FSM states: IDLE, LOAD, RUN, ABORT.
  - IDLE → LOAD when queue_count != 0.
  - LOAD, one cycle:
    - Pops the head into the move_* output registers and the internal last_r flag.
    - move_start = 1 exactly during this cycle; move_* values are valid from this cycle.
    - Next state is RUN.
  - RUN, on move_done:
    - moves_completed increments.
    - Next state is LOAD if queue_count != 0, else IDLE.
    - If the queue is empty and last_r == 0, underrun is set.
  - Any state, on abort:
    - Next state is ABORT.
    - FIFO is flushed (queue_count = 0 at the next edge).
  - ABORT, one cycle: move_abort = 1, cmd_ready = 0, then IDLE.
- Latency:
  - Push into an empty, idle scheduler at cycle N: queue_count = 1 at N+1, move_start at N+2.
  - move_done at cycle N with a non-empty queue: move_start at N+1.
- Holding: move_* outputs hold their value until the next LOAD. They are not cleared on done or abort.
- move_done outside RUN (IDLE, LOAD, ABORT) is ignored and does not count.
- Simultaneous events:
  - abort && move_done: abort wins, no count increment, no underrun.
  - abort && cmd_valid: the command is dropped; cmd_ready may be high in the abort cycle, but the flush overrides the push.
  - abort while in ABORT: stays in ABORT one more cycle and pulses move_abort again.
  - underrun_clear together with an underrun set: the set wins.
- Reset mid-move: state returns to IDLE immediately. No move_abort pulse is generated; the executor is reset by the same signal.
- Arithmetic:
  - FIFO pointers are $clog2(DEPTH) bits and wrap naturally.
  - The occupancy counter is separate, width $clog2(DEPTH+1).
  - Increment fields pass through untouched; sign is preserved bitwise.

Decomposition:
- Shared package move_pkg holds:
  - State encodings IDLE=0, LOAD=1, RUN=2, ABORT=3.
  - MOVE_CMD_W = 2 + 3*MOVE_WIDTH.
  - Field offsets for the packed command word (dir, last, duration, increment, incrementincrement).
- Sub-module move_fifo:
  - Synchronous FIFO with push/pop/flush, count, full and empty.
  - DEPTH × MOVE_CMD_W storage.
- move_scheduler holds the FSM, output registers and status counters.

Test Plan:
- Single move: push {dir=1, last=1, duration=100, inc=5, incinc=0} at cycle 10 → move_start at 12, move_duration=100. After move_done at 40: moves_completed=1, busy=0, underrun=0.
- Back-to-back: push 3 moves, each with last=0 except the third. Each move_done at cycle N → move_start at N+1 with the next command's fields in order; moves_completed=3, underrun=0.
- Underrun: push one move with last=0, then pulse move_done → underrun=1 and the state is IDLE. Pulse underrun_clear → underrun=0.
- Full FIFO: with the executor stalled, push DEPTH+1=5 commands → after the first is popped, queue_count reaches 4 and cmd_ready=0. The 6th valid is not accepted until the next move_done/LOAD frees a slot.
- Abort: with 3 queued and one running, assert abort together with move_done → move_abort pulses once the next cycle, queue_count=0, moves_completed unchanged, no further move_start.
- Reset mid-RUN: assert reset for 1 cycle → busy=0, queue_count=0, moves_completed=0, move_duration=0, cmd_ready=1 the cycle after reset drops.

Source files
------------

// File: rtl/move_pkg.sv
// Shared types and packed-command layout for the move scheduler and its queue.
package move_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ABORT = 2'd3
  } move_state_e;

  localparam int MOVE_WIDTH_DFLT = 64;

  function automatic int move_cmd_w(input int mw);
    return 2 + 3 * mw;
  endfunction

  localparam int MOVE_CMD_W = 2 + 3 * MOVE_WIDTH_DFLT;

  // Command word, LSB first: incrementincrement, increment, duration, last, dir
  localparam int OFS_IINC = 0;

  function automatic int ofs_inc(input int mw);
    return mw;
  endfunction

  function automatic int ofs_dur(input int mw);
    return 2 * mw;
  endfunction

  function automatic int ofs_last(input int mw);
    return 3 * mw;
  endfunction

  function automatic int ofs_dir(input int mw);
    return 3 * mw + 1;
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous first-word-fall-through FIFO for packed move commands; flush beats push/pop.
module move_fifo
  import move_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = MOVE_CMD_W
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int QW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [QW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == QW'(DEPTH));
  assign empty     = (count_r == {QW{1'b0}});
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full && !flush;
  assign do_pop_s  = pop && !empty && !flush;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge CLK) begin
    if (reset || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {QW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + QW'(1'b1);
        2'b01:   count_r <= count_r - QW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Command storage write port
  always_ff @(posedge CLK) begin
    if (do_push_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/move_scheduler.sv
// Queues coordinated moves and launches them one at a time into the step generator,
// holding move parameters stable and tracking completion and starvation status.
module move_scheduler
  import move_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int MOVE_WIDTH  = MOVE_WIDTH_DFLT,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_dir,
  input  logic                       cmd_last,
  input  logic [MOVE_WIDTH-1:0]      cmd_duration,
  input  logic [MOVE_WIDTH-1:0]      cmd_increment,
  input  logic [MOVE_WIDTH-1:0]      cmd_incrementincrement,
  input  logic                       abort,
  output logic                       move_start,
  output logic                       move_dir,
  output logic [MOVE_WIDTH-1:0]      move_duration,
  output logic [MOVE_WIDTH-1:0]      move_increment,
  output logic [MOVE_WIDTH-1:0]      move_incrementincrement,
  input  logic                       move_done,
  output logic                       move_abort,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  output logic [COUNT_WIDTH-1:0]     moves_completed,
  output logic                       underrun,
  input  logic                       underrun_clear
);

  localparam int CMD_W    = move_cmd_w(MOVE_WIDTH);
  localparam int OFS_INC  = ofs_inc(MOVE_WIDTH);
  localparam int OFS_DUR  = ofs_dur(MOVE_WIDTH);
  localparam int OFS_LAST = ofs_last(MOVE_WIDTH);
  localparam int OFS_DIR  = ofs_dir(MOVE_WIDTH);

  move_state_e            state_r;
  logic [CMD_W-1:0]       cmd_word_s;
  logic [CMD_W-1:0]       head_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic                   push_s;
  logic                   load_s;
  logic                   underrun_set_s;
  logic                   last_r;
  logic                   move_start_r;
  logic                   move_abort_r;
  logic                   move_dir_r;
  logic [MOVE_WIDTH-1:0]  move_duration_r;
  logic [MOVE_WIDTH-1:0]  move_increment_r;
  logic [MOVE_WIDTH-1:0]  move_incrementincrement_r;
  logic                   busy_r;
  logic                   underrun_r;
  logic [COUNT_WIDTH-1:0] moves_completed_r;

  assign cmd_word_s = {cmd_dir, cmd_last, cmd_duration, cmd_increment, cmd_incrementincrement};
  // The ready check deliberately ignores a same-cycle pop.
  assign cmd_ready  = !reset && !fifo_full_s && (state_r != ST_ABORT);
  assign push_s     = cmd_valid && cmd_ready && !abort;
  // A move is popped on the edge that enters LOAD, so its fields are valid during LOAD.
  assign load_s     = !abort && !fifo_empty_s &&
                      ((state_r == ST_IDLE) || ((state_r == ST_RUN) && move_done));
  assign underrun_set_s = (state_r == ST_RUN) && move_done && !abort && fifo_empty_s && !last_r;

  move_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (push_s),
    .pop   (load_s),
    .flush (abort),
    .din   (cmd_word_s),
    .dout  (head_s),
    .count (queue_count),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Sequencing FSM with registered move parameters and status
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r                   <= ST_IDLE;
      last_r                    <= 1'b0;
      move_start_r              <= 1'b0;
      move_abort_r              <= 1'b0;
      move_dir_r                <= 1'b0;
      move_duration_r           <= {MOVE_WIDTH{1'b0}};
      move_increment_r          <= {MOVE_WIDTH{1'b0}};
      move_incrementincrement_r <= {MOVE_WIDTH{1'b0}};
      busy_r                    <= 1'b0;
      underrun_r                <= 1'b0;
      moves_completed_r         <= {COUNT_WIDTH{1'b0}};
    end else begin
      move_start_r <= load_s;
      move_abort_r <= abort;
      if (load_s) begin
        move_dir_r                <= head_s[OFS_DIR];
        last_r                    <= head_s[OFS_LAST];
        move_duration_r           <= head_s[OFS_DUR +: MOVE_WIDTH];
        move_increment_r          <= head_s[OFS_INC +: MOVE_WIDTH];
        move_incrementincrement_r <= head_s[OFS_IINC +: MOVE_WIDTH];
      end
      if (underrun_set_s) begin
        underrun_r <= 1'b1;
      end else if (underrun_clear) begin
        underrun_r <= 1'b0;
      end
      if (abort) begin
        state_r <= ST_ABORT;
        busy_r  <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= load_s ? ST_LOAD : ST_IDLE;
            busy_r  <= load_s;
          end
          ST_LOAD: begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
          end
          ST_RUN: begin
            if (move_done) begin
              moves_completed_r <= moves_completed_r + COUNT_WIDTH'(1'b1);
              state_r           <= load_s ? ST_LOAD : ST_IDLE;
              busy_r            <= load_s;
            end else begin
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
            end
          end
          ST_ABORT: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign move_start              = move_start_r;
  assign move_abort              = move_abort_r;
  assign move_dir                = move_dir_r;
  assign move_duration           = move_duration_r;
  assign move_increment          = move_increment_r;
  assign move_incrementincrement = move_incrementincrement_r;
  assign busy                    = busy_r;
  assign underrun                = underrun_r;
  assign moves_completed         = moves_completed_r;

endmodule
